drop_engine: RTL

DROP_ENGINE -- requirements
Module: drop_engine

---
 rtl/tetris_pkg.sv | 18 +
 rtl/drop_engine_if.sv | 34 +++
 rtl/drop_engine_timer.sv | 30 +++
 rtl/drop_engine.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared board geometry and coordinate widths for the falling-block engine.
// No logic, no latency.
// No flow control.
package tetris_pkg;

    localparam int COLS      = 10;
    localparam int ROWS      = 20;
    localparam int SPAWN_COL = 4;
    localparam int X_W       = $clog2(COLS);
    localparam int Y_W       = $clog2(ROWS);
    localparam int BOARD_W   = ROWS * COLS;

    // Flat board index of cell (row r, column c); row 0 is the top row.
    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/drop_engine_if.sv
// Control and status bundle between the game FSM (master) and the drop engine (slave).
// Pure wiring, no latency.
// Level/pulse controls, no backpressure.
interface drop_engine_if #(
    parameter int COLS = tetris_pkg::COLS,
    parameter int ROWS = tetris_pkg::ROWS
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);

    logic                 load_block;
    logic                 drop_block;
    logic                 update_board_state;
    logic                 move_left;
    logic                 move_right;
    logic                 filled_under;
    logic [XW-1:0]        block_x;
    logic [YW-1:0]        block_y;
    logic                 block_valid;
    logic [ROWS*COLS-1:0] board;
    logic [7:0]           lines_cleared;
    logic                 game_over;

    modport master (
        output load_block, drop_block, update_board_state, move_left, move_right,
        input  filled_under, block_x, block_y, block_valid, board, lines_cleared, game_over
    );

    modport slave (
        input  load_block, drop_block, update_board_state, move_left, move_right,
        output filled_under, block_x, block_y, block_valid, board, lines_cleared, game_over
    );

endinterface

// File: rtl/drop_engine_timer.sv
// Gravity timer: emits a one-cycle step every PERIOD enabled cycles.
// step is combinational from the registered count; count updates on the same edge.
// Holds its count while disabled; clear/reset force zero.
module drop_timer #(
    parameter int PERIOD = 25000000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic step
);
    localparam int            CW   = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] r_count;

    assign step = enable && (r_count == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (step) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/drop_engine.sv
// Single-cell falling block on a flop-based board: spawn, gravity, lateral moves, commit + row clear.
// All state updates in one edge; filled_under is combinational.
// No backpressure: controls are levels/pulses from the game FSM, overlapping ones resolved by priority.
module drop_engine #(
    parameter int COLS        = tetris_pkg::COLS,
    parameter int ROWS        = tetris_pkg::ROWS,
    parameter int SPAWN_COL   = tetris_pkg::SPAWN_COL,
    parameter int DROP_PERIOD = 25000000
) (
    input  logic         clock,
    input  logic         reset,
    drop_engine_if.slave bus
);
    import tetris_pkg::*;

    localparam int            XW      = $clog2(COLS);
    localparam int            YW      = $clog2(ROWS);
    localparam int            BW      = ROWS * COLS;
    localparam logic [XW-1:0] X_LAST  = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(ROWS - 1);
    localparam logic [XW-1:0] SPAWN_X = XW'(SPAWN_COL);

    logic [BW-1:0] r_board;
    logic [XW-1:0] r_block_x;
    logic [YW-1:0] r_block_y;
    logic          r_block_valid;
    logic [7:0]    r_lines_cleared;
    logic          r_game_over;

    logic          w_filled_under;
    logic          w_step;
    logic          w_timer_en;
    logic          w_timer_clr;
    logic          w_can_left;
    logic          w_can_right;
    logic          w_spawn_blocked;
    logic          w_row_full;
    logic [BW-1:0] w_written;
    logic [BW-1:0] w_commit_board;

    // Out-of-range coordinates read as empty so edge checks need no special casing.
    function automatic logic cell_at(input logic [BW-1:0] b, input int r, input int c);
        logic [BW-1:0] t;
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) begin
            return 1'b0;
        end
        t = b >> cell_idx(r, c, COLS);
        return t[0];
    endfunction

    assign w_filled_under  = r_block_valid &&
                             ((r_block_y == Y_LAST) ||
                              cell_at(r_board, int'(r_block_y) + 1, int'(r_block_x)));
    assign w_spawn_blocked = cell_at(r_board, 0, SPAWN_COL);
    assign w_can_left      = (r_block_x != '0) &&
                             !cell_at(r_board, int'(r_block_y), int'(r_block_x) - 1);
    assign w_can_right     = (r_block_x != X_LAST) &&
                             !cell_at(r_board, int'(r_block_y), int'(r_block_x) + 1);

    assign w_timer_clr = bus.load_block;
    assign w_timer_en  = bus.drop_block && r_block_valid && !w_filled_under &&
                         !bus.load_block && !bus.update_board_state;

    drop_timer #(
        .PERIOD (DROP_PERIOD)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .enable (w_timer_en),
        .clear  (w_timer_clr),
        .step   (w_step)
    );

    // Next board on commit: write the cell, and if its row fills, collapse everything above it by one.
    always_comb begin
        w_written  = r_board | (BW'(1) << cell_idx(int'(r_block_y), int'(r_block_x), COLS));
        w_row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (!cell_at(w_written, int'(r_block_y), c)) begin
                w_row_full = 1'b0;
            end
        end
        w_commit_board = w_written;
        if (w_row_full) begin
            for (int c = 0; c < COLS; c++) begin
                w_commit_board[c] = 1'b0;
            end
            for (int r = 1; r < ROWS; r++) begin
                if (r <= int'(r_block_y)) begin
                    for (int c = 0; c < COLS; c++) begin
                        w_commit_board[r*COLS + c] = w_written[(r-1)*COLS + c];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_board         <= '0;
            r_block_x       <= SPAWN_X;
            r_block_y       <= '0;
            r_block_valid   <= 1'b0;
            r_lines_cleared <= '0;
            r_game_over     <= 1'b0;
        end else if (bus.load_block) begin
            if (w_spawn_blocked) begin
                r_game_over   <= 1'b1;
                r_block_valid <= 1'b0;
            end else begin
                r_block_x     <= SPAWN_X;
                r_block_y     <= '0;
                r_block_valid <= 1'b1;
            end
        end else if (bus.update_board_state) begin
            if (r_block_valid) begin
                r_board       <= w_commit_board;
                r_block_valid <= 1'b0;
                if (w_row_full) begin
                    r_lines_cleared <= r_lines_cleared + 8'd1;
                end
            end
        end else if (bus.drop_block) begin
            // A gravity step swallows any move request of the same cycle.
            if (w_step) begin
                r_block_y <= r_block_y + 1'b1;
            end else if (bus.move_left && !bus.move_right && w_can_left) begin
                r_block_x <= r_block_x - 1'b1;
            end else if (bus.move_right && !bus.move_left && w_can_right) begin
                r_block_x <= r_block_x + 1'b1;
            end
        end
    end

    assign bus.filled_under  = w_filled_under;
    assign bus.block_x       = r_block_x;
    assign bus.block_y       = r_block_y;
    assign bus.block_valid   = r_block_valid;
    assign bus.board         = r_board;
    assign bus.lines_cleared = r_lines_cleared;
    assign bus.game_over     = r_game_over;

endmodule
